hazard_div_ctrl: RTL and testbench
==================================

// Module: hazard_div_ctrl
// PURPOSE
//  Pipeline hazard controller and divider sequencer for the IF/ID/EX core.
//  - Drives decoder forwarding selects (fwd_reg1_o/fwd_reg2_o).
//  - Inserts load-use bubbles and applies jump flushes.
//  - Sequences the multi-cycle divider: start, busy hold, done.
//  - Sits between the ID stage, the EX stage, the PC/IF_ID/ID_EX registers and the divider.
// PARAMETERS
//  DIV_CYCLES  33  EX-to-result latency of the divider, in cycles; legal range >= 2
// PORTS
//  clk              in   1  core clock
//  rst              in   1  asynchronous reset, active-high
//  id_reg1_raddr_i  in   5  rs1 read by the ID instruction; x0 = unused
//  id_reg2_raddr_i  in   5  rs2 read by the ID instruction; x0 = unused
//  ex_reg_we_i      in   1  EX instruction writes a GPR
//  ex_reg_waddr_i   in   5  EX destination GPR
//  ex_is_load_i     in   1  EX instruction is a load
//  ex_div_req_i     in   1  EX instruction is DIV/DIVU/REM/REMU
//  ex_div_waddr_i   in   5  rd of the EX divide
//  ex_jump_flag_i   in   1  EX redirects the PC (branch/jump/div pc+4)
//  int_assert_i     in   1  interrupt taken this cycle
//  fwd_reg1_o       out  1  ID rs1 takes the EX result
//  fwd_reg2_o       out  1  ID rs2 takes the EX result
//  stall_pc_o       out  1  hold the PC
//  stall_if_id_o    out  1  hold the IF_ID register
//  flush_if_id_o    out  1  load NOP into IF_ID
//  flush_id_ex_o    out  1  load NOP into ID_EX
//  div_start_o      out  1  one-cycle divider start pulse
//  div_busy_o       out  1  divider operation in flight
//  div_done_o       out  1  one-cycle pulse; divider result written to div_waddr_o
//  div_waddr_o      out  5  latched rd of the active divide
// BEHAVIOUR
//  Reset state
//  - rst asynchronously forces state=IDLE, cnt=0, div_waddr_o=0.
//  - While rst is high, all outputs are 0.
//  Forwarding (combinational, every state)
//  - match1 = ex_reg_we_i & ex_reg_waddr_i!=0 & ex_reg_waddr_i==id_reg1_raddr_i; match2 likewise for rs2.
//  - fwd_regN_o = matchN & ~ex_is_load_i.
//  Load-use (IDLE only)
//  - lu = ex_is_load_i & (match1|match2).
//  - lu asserts stall_pc_o, stall_if_id_o and flush_id_ex_o for exactly one cycle.
//  - Next cycle the load is in MEM; ID re-reads from the register file.
//  Jump (IDLE only)
//  - ex_jump_flag_i asserts flush_if_id_o and flush_id_ex_o.
//  - Jump overrides lu: no stall is applied that cycle.
//  FSM: IDLE -> BUSY -> DONE -> IDLE
//  IDLE
//  - ex_div_req_i & ~int_assert_i: div_start_o=1, div_waddr_o<=ex_div_waddr_i, cnt<=DIV_CYCLES-2, go to BUSY.
//  - The accompanying pc+4 jump flush is applied in the same cycle.
//  BUSY
//  - div_busy_o=1; stall_pc_o, stall_if_id_o and flush_id_ex_o are held high.
//  - cnt decrements each cycle; cnt==0 -> DONE.
//  DONE
//  - div_busy_o=1, div_done_o=1; stalls are still held.
//  - The GPR write occurs at the end of this cycle; next state IDLE, where ID reads the new value.
//  - Total time from div_start_o to div_done_o is DIV_CYCLES-1 cycles.
//  - EX carries only bubbles in BUSY/DONE, so there is no write-port conflict.
//  int_assert_i in BUSY or DONE
//  - Abort: next state IDLE, div_done_o is not pulsed, flush_if_id_o=flush_id_ex_o=1.
//  - div_waddr_o keeps its last value.
//  int_assert_i in IDLE with ex_div_req_i
//  - The divide is not started; flushes are applied.
//  Counter width: $clog2(DIV_CYCLES); no wrap; cnt stays 0 outside BUSY.
//  rst mid-operation: immediate return to IDLE; no done pulse.
// TESTING
//  - EX addi x5 (we=1, waddr=5, load=0), ID rs1=5, rs2=0 -> fwd_reg1_o=1, fwd_reg2_o=0, no stall.
//  - EX lw x7, ID rs2=7 -> one cycle of stall_pc_o=stall_if_id_o=flush_id_ex_o=1, fwd_reg2_o=0; next cycle all 0.
//  - EX lw x7, ID rs1=7, ex_jump_flag_i=1 -> flush_if_id_o=flush_id_ex_o=1, stall_pc_o=0.
//  - DIV_CYCLES=4, div rd=9 at T0 -> div_start_o@T0; busy@T1..T3; div_done_o@T3 only, div_waddr_o=9; stalls drop @T4.
//  - DIV_CYCLES=4, int_assert_i@T2 -> IDLE@T3, no div_done_o, flushes@T2.
//  - rst pulse at T2 mid-divide -> all outputs 0 immediately; IDLE, cnt=0 after release.

Source files
------------

// File: rtl/hazard_div_ctrl.sv
// Hazard controller for the IF/ID/EX core: forwarding selects, load-use bubbles,
// jump flushes and the multi-cycle divider sequencer (IDLE -> BUSY -> DONE).
module hazard_div_ctrl #(
    parameter int unsigned DIV_CYCLES = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_reg1_raddr_i,
    input  logic [4:0] id_reg2_raddr_i,
    input  logic       ex_reg_we_i,
    input  logic [4:0] ex_reg_waddr_i,
    input  logic       ex_is_load_i,
    input  logic       ex_div_req_i,
    input  logic [4:0] ex_div_waddr_i,
    input  logic       ex_jump_flag_i,
    input  logic       int_assert_i,
    output logic       fwd_reg1_o,
    output logic       fwd_reg2_o,
    output logic       stall_pc_o,
    output logic       stall_if_id_o,
    output logic       flush_if_id_o,
    output logic       flush_id_ex_o,
    output logic       div_start_o,
    output logic       div_busy_o,
    output logic       div_done_o,
    output logic [4:0] div_waddr_o
);

    localparam int unsigned CntW = $clog2(DIV_CYCLES);
    localparam logic [CntW-1:0] CntLoad = CntW'(DIV_CYCLES - 2);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [4:0]      waddr_q;

    logic match1, match2, load_use, redirect, start;

    always_comb begin
        match1   = ex_reg_we_i && (ex_reg_waddr_i != 5'd0) && (ex_reg_waddr_i == id_reg1_raddr_i);
        match2   = ex_reg_we_i && (ex_reg_waddr_i != 5'd0) && (ex_reg_waddr_i == id_reg2_raddr_i);
        load_use = ex_is_load_i && (match1 || match2);
        // A divide in EX always redirects to pc+4, so treat it like a jump.
        redirect = ex_jump_flag_i || ex_div_req_i;
        start    = (state_q == StIdle) && ex_div_req_i && !int_assert_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            waddr_q <= 5'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        waddr_q <= ex_div_waddr_i;
                        cnt_q   <= CntLoad;
                        // Shortest divider has no BUSY cycle at all.
                        state_q <= (DIV_CYCLES == 2) ? StDone : StBusy;
                    end
                end
                StBusy: begin
                    if (int_assert_i) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - CntW'(1);
                        end
                        if (cnt_q <= CntW'(1)) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        fwd_reg1_o    = 1'b0;
        fwd_reg2_o    = 1'b0;
        stall_pc_o    = 1'b0;
        stall_if_id_o = 1'b0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        div_start_o   = 1'b0;
        div_busy_o    = 1'b0;
        div_done_o    = 1'b0;
        div_waddr_o   = 5'd0;
        if (!rst) begin
            fwd_reg1_o  = match1 && !ex_is_load_i;
            fwd_reg2_o  = match2 && !ex_is_load_i;
            div_waddr_o = waddr_q;
            unique case (state_q)
                StIdle: begin
                    stall_pc_o    = load_use && !redirect;
                    stall_if_id_o = load_use && !redirect;
                    flush_if_id_o = redirect;
                    flush_id_ex_o = redirect || load_use;
                    div_start_o   = start;
                end
                StBusy, StDone: begin
                    // An interrupt aborts the divide and lets the PC take the vector.
                    div_busy_o    = 1'b1;
                    div_done_o    = (state_q == StDone) && !int_assert_i;
                    stall_pc_o    = !int_assert_i;
                    stall_if_id_o = !int_assert_i;
                    flush_if_id_o = int_assert_i;
                    flush_id_ex_o = 1'b1;
                end
                default: begin
                    flush_id_ex_o = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_div_ctrl.sv
// Self-checking bench for hazard_div_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-age model of the divider and the hazard rules.
module tb_hazard_div_ctrl;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_r1 = '0, id_r2 = '0, ex_wa = '0, ex_dwa = '0;
    logic       ex_we = 1'b0, ex_ld = 1'b0, ex_dreq = 1'b0, ex_jmp = 1'b0, intr = 1'b0;

    logic       fwd_reg1_o, fwd_reg2_o, stall_pc_o, stall_if_id_o, flush_if_id_o;
    logic       flush_id_ex_o, div_start_o, div_busy_o, div_done_o;
    logic [4:0] div_waddr_o;

    int vectors = 0;
    int miscompares = 0;

    // Model: is a divide in flight, how many cycles since its start, latched rd.
    bit         m_active = 1'b0;
    int         m_age = 0;
    logic [4:0] m_waddr = '0;

    hazard_div_ctrl #(.DIV_CYCLES(DC)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_reg1_raddr_i(id_r1),
        .id_reg2_raddr_i(id_r2),
        .ex_reg_we_i    (ex_we),
        .ex_reg_waddr_i (ex_wa),
        .ex_is_load_i   (ex_ld),
        .ex_div_req_i   (ex_dreq),
        .ex_div_waddr_i (ex_dwa),
        .ex_jump_flag_i (ex_jmp),
        .int_assert_i   (intr),
        .fwd_reg1_o     (fwd_reg1_o),
        .fwd_reg2_o     (fwd_reg2_o),
        .stall_pc_o     (stall_pc_o),
        .stall_if_id_o  (stall_if_id_o),
        .flush_if_id_o  (flush_if_id_o),
        .flush_id_ex_o  (flush_id_ex_o),
        .div_start_o    (div_start_o),
        .div_busy_o     (div_busy_o),
        .div_done_o     (div_done_o),
        .div_waddr_o    (div_waddr_o)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] obs_vec();
        return {fwd_reg1_o, fwd_reg2_o, stall_pc_o, stall_if_id_o, flush_if_id_o, flush_id_ex_o,
                div_start_o, div_busy_o, div_done_o, div_waddr_o};
    endfunction

    function automatic logic [13:0] exp_vec();
        logic m1, m2, lu, redir, sp, fi, fe, st, bz, dn;
        if (rst) return '0;
        m1 = ex_we && (ex_wa != 5'd0) && (ex_wa == id_r1);
        m2 = ex_we && (ex_wa != 5'd0) && (ex_wa == id_r2);
        if (!m_active) begin
            lu    = ex_ld && (m1 || m2);
            redir = ex_jmp || ex_dreq;
            sp    = lu && !redir;
            fi    = redir;
            fe    = redir || lu;
            st    = ex_dreq && !intr;
            bz    = 1'b0;
            dn    = 1'b0;
        end else begin
            sp    = !intr;
            fi    = intr;
            fe    = 1'b1;
            st    = 1'b0;
            bz    = 1'b1;
            dn    = (m_age == DC - 1) && !intr;
        end
        return {m1 && !ex_ld, m2 && !ex_ld, sp, sp, fi, fe, st, bz, dn, m_waddr};
    endfunction

    function automatic void model_step();
        if (rst) begin
            m_active = 1'b0;
            m_age    = 0;
            m_waddr  = '0;
        end else if (!m_active) begin
            if (ex_dreq && !intr) begin
                m_active = 1'b1;
                m_age    = 1;
                m_waddr  = ex_dwa;
            end
        end else if (intr || m_age == DC - 1) begin
            m_active = 1'b0;
        end else begin
            m_age++;
        end
    endfunction

    task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic we,
                         input logic [4:0] wa, input logic ld, input logic dreq,
                         input logic [4:0] dwa, input logic jmp, input logic it);
        id_r1 = r1; id_r2 = r2; ex_we = we; ex_wa = wa; ex_ld = ld;
        ex_dreq = dreq; ex_dwa = dwa; ex_jmp = jmp; intr = it;
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        drive(5'd3, 5'd3, 1'b1, 5'd3, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0);
        #1;
        vectors++;
        if (obs_vec() !== 14'd0) begin
            $display("FAIL reset_outputs: got %b exp %b", obs_vec(), 14'd0);
            miscompares++;
        end
        advance();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (obs_vec() !== exp_vec() || div_busy_o !== 1'b0) begin
            $display("FAIL reset_release: got %b exp %b", obs_vec(), exp_vec());
            miscompares++;
        end
        advance();
    endtask

    task automatic test_forwarding();
        // addi x5 in EX, ID reads rs1=x5
        drive(5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        vectors++;
        if (fwd_reg1_o !== 1'b1 || fwd_reg2_o !== 1'b0 || stall_pc_o !== 1'b0) begin
            $display("FAIL fwd_addi: got f1=%b f2=%b stall=%b exp 1 0 0",
                     fwd_reg1_o, fwd_reg2_o, stall_pc_o);
            miscompares++;
        end
        advance();
        // lw x7 in EX, ID reads rs2=x7 -> one-cycle bubble
        drive(5'd0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        vectors++;
        if ({stall_pc_o, stall_if_id_o, flush_id_ex_o, fwd_reg2_o} !== 4'b1110) begin
            $display("FAIL load_use: got %b exp 1110",
                     {stall_pc_o, stall_if_id_o, flush_id_ex_o, fwd_reg2_o});
            miscompares++;
        end
        advance();
        drive(5'd0, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        vectors++;
        if (obs_vec() !== exp_vec() || {stall_pc_o, stall_if_id_o, flush_id_ex_o} !== 3'b000) begin
            $display("FAIL load_use_next: got %b exp %b", obs_vec(), exp_vec());
            miscompares++;
        end
        advance();
        // lw x7 with a jump in EX -> flush wins over stall
        drive(5'd7, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        vectors++;
        if ({flush_if_id_o, flush_id_ex_o, stall_pc_o, stall_if_id_o} !== 4'b1100) begin
            $display("FAIL jump_over_lu: got %b exp 1100",
                     {flush_if_id_o, flush_id_ex_o, stall_pc_o, stall_if_id_o});
            miscompares++;
        end
        advance();
    endtask

    task automatic test_divide();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0);
        @(negedge clk);
        vectors++;
        if (div_start_o !== 1'b1 || flush_if_id_o !== 1'b1 || obs_vec() !== exp_vec()) begin
            $display("FAIL div_start: got %b exp %b", obs_vec(), exp_vec());
            miscompares++;
        end
        advance();
        for (int t = 1; t <= DC; t++) begin
            drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
            @(negedge clk);
            vectors++;
            if (div_busy_o !== (t < DC) || div_done_o !== (t == DC - 1) ||
                stall_pc_o !== (t < DC) || div_waddr_o !== 5'd9) begin
                $display("FAIL div_seq_T%0d: got busy=%b done=%b stall=%b rd=%0d exp %b %b %b 9",
                         t, div_busy_o, div_done_o, stall_pc_o, div_waddr_o,
                         t < DC, t == DC - 1, t < DC);
                miscompares++;
            end
            advance();
        end
    endtask

    task automatic test_div_abort();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);
        advance();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        advance();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        @(negedge clk);
        vectors++;
        if ({flush_if_id_o, flush_id_ex_o, div_done_o} !== 3'b110 || obs_vec() !== exp_vec()) begin
            $display("FAIL div_abort: got %b exp %b", obs_vec(), exp_vec());
            miscompares++;
        end
        advance();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        vectors++;
        if (div_busy_o !== 1'b0 || div_done_o !== 1'b0 || div_waddr_o !== 5'd3) begin
            $display("FAIL div_abort_idle: got busy=%b done=%b rd=%0d exp 0 0 3",
                     div_busy_o, div_done_o, div_waddr_o);
            miscompares++;
        end
        advance();
    endtask

    task automatic test_rst_mid();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd12, 1'b1, 1'b0);
        advance();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        advance();
        rst = 1'b1;
        m_active = 1'b0;
        m_waddr  = '0;
        #1;
        vectors++;
        if (obs_vec() !== 14'd0) begin
            $display("FAIL rst_mid_outputs: got %b exp %b", obs_vec(), 14'd0);
            miscompares++;
        end
        advance();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (obs_vec() !== exp_vec() || div_busy_o !== 1'b0 || dut.cnt_q !== '0) begin
            $display("FAIL rst_mid_release: got %b cnt=%0d exp %b cnt=0",
                     obs_vec(), dut.cnt_q, exp_vec());
            miscompares++;
        end
        advance();
    endtask

    task automatic test_random();
        logic dreq;
        for (int i = 0; i < 400; i++) begin
            dreq = ($urandom_range(0, 99) < 10);
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 99) < 30), dreq,
                  5'($urandom), dreq || ($urandom_range(0, 99) < 10),
                  ($urandom_range(0, 99) < 6));
            rst = ($urandom_range(0, 99) < 2);
            @(negedge clk);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL random_%0d: got %b exp %b", i, obs_vec(), exp_vec());
                miscompares++;
            end
            advance();
        end
        rst = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_forwarding();
        test_divide();
        test_div_abort();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
